// File: rtl/ssd_scan_scheduler.sv
// Two-digit seven-segment scan scheduler: captures keypad presses into a
// two-entry shift register and multiplexes the Pmod digit select with blanking.
module ssd_scan_scheduler #(
    parameter int clk_freq     = 125_000_000,
    parameter int refresh_hz   = 100,
    parameter int blank_cycles = 1250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode,
    input  logic       toggle_pulse,
    input  logic       clear,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [3:0] disp_val,
    output logic       disp_blank,
    output logic       chip_sel,
    output logic [3:0] left_digit,
    output logic [3:0] right_digit,
    output logic [1:0] digit_count,
    output logic       key_event
);

    localparam int DWELL   = clk_freq / (2 * refresh_hz);
    localparam int CNT_MAX = (DWELL > blank_cycles) ? DWELL : blank_cycles;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(blank_cycles - 1);

    typedef enum logic [1:0] {
        SHOW_R  = 2'd0,
        BLANK_L = 2'd1,
        SHOW_L  = 2'd2,
        BLANK_R = 2'd3
    } scan_state_t;

    scan_state_t   state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          mode_reg;
    logic          toggle_reg, toggle_next;

    logic          kv_reg, kv_prev_reg, clear_reg;
    logic          press;

    logic [3:0]    left_reg, left_next;
    logic [3:0]    right_reg, right_next;
    logic [1:0]    count_reg, count_next;
    logic          key_event_reg, key_event_next;

    logic [3:0]    disp_val_reg, disp_val_next;
    logic          disp_blank_reg, disp_blank_next;
    logic          chip_sel_reg, chip_sel_next;
    logic [CW-1:0] cnt_last;

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= SHOW_R;
            cnt_reg        <= '0;
            // Starts high so a scan already selected through reset begins in
            // SHOW_R rather than taking the static-to-scan blanking entry.
            mode_reg       <= 1'b1;
            toggle_reg     <= 1'b0;
            kv_reg         <= 1'b0;
            kv_prev_reg    <= 1'b0;
            clear_reg      <= 1'b0;
            left_reg       <= 4'd0;
            right_reg      <= 4'd0;
            count_reg      <= 2'd0;
            key_event_reg  <= 1'b0;
            disp_val_reg   <= 4'd0;
            disp_blank_reg <= 1'b1;
            chip_sel_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            mode_reg       <= mode;
            toggle_reg     <= toggle_next;
            kv_reg         <= key_valid;
            kv_prev_reg    <= kv_reg;
            clear_reg      <= clear;
            left_reg       <= left_next;
            right_reg      <= right_next;
            count_reg      <= count_next;
            key_event_reg  <= key_event_next;
            disp_val_reg   <= disp_val_next;
            disp_blank_reg <= disp_blank_next;
            chip_sel_reg   <= chip_sel_next;
        end
    end

    // ------------------------------------------------------------------
    // Key capture: a rise sampled while clear was asserted is discarded,
    // so a key held across clear only counts after a genuine re-press.
    // ------------------------------------------------------------------
    always_comb begin
        press          = kv_reg & ~kv_prev_reg & ~clear_reg;
        left_next      = left_reg;
        right_next     = right_reg;
        count_next     = count_reg;
        key_event_next = 1'b0;
        if (clear) begin
            left_next  = 4'd0;
            right_next = 4'd0;
            count_next = 2'd0;
        end else if (press) begin
            left_next      = right_reg;
            right_next     = key_code;
            count_next     = (count_reg == 2'd2) ? 2'd2 : count_reg + 2'd1;
            key_event_next = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Scan FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        toggle_next = toggle_reg ^ (toggle_pulse & ~mode);
        cnt_last    = ((state_reg == SHOW_R) || (state_reg == SHOW_L)) ? DWELL_LAST : BLANK_LAST;
        if (!mode) begin
            state_next = SHOW_R;
            cnt_next   = '0;
        end else if (!mode_reg) begin
            state_next = BLANK_L;
            cnt_next   = '0;
        end else if (cnt_reg == cnt_last) begin
            cnt_next = '0;
            unique case (state_reg)
                SHOW_R:  state_next = BLANK_L;
                BLANK_L: state_next = SHOW_L;
                SHOW_L:  state_next = BLANK_R;
                BLANK_R: state_next = SHOW_R;
                default: state_next = SHOW_R;
            endcase
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Display outputs decoded from next-state values so the registered
    // outputs line up with the state and digit registers they describe.
    // ------------------------------------------------------------------
    always_comb begin
        disp_val_next   = 4'd0;
        disp_blank_next = 1'b1;
        chip_sel_next   = 1'b0;
        if (!mode) begin
            chip_sel_next   = toggle_next;
            disp_val_next   = right_next;
            disp_blank_next = (count_next == 2'd0);
        end else begin
            unique case (state_next)
                SHOW_R: begin
                    chip_sel_next   = 1'b0;
                    disp_val_next   = right_next;
                    disp_blank_next = (count_next == 2'd0);
                end
                BLANK_L: begin
                    chip_sel_next   = 1'b1;
                    disp_blank_next = 1'b1;
                end
                SHOW_L: begin
                    chip_sel_next   = 1'b1;
                    disp_val_next   = left_next;
                    disp_blank_next = (count_next < 2'd2);
                end
                BLANK_R: begin
                    chip_sel_next   = 1'b0;
                    disp_blank_next = 1'b1;
                end
                default: begin
                    chip_sel_next   = 1'b0;
                    disp_blank_next = 1'b1;
                end
            endcase
        end
    end

    assign disp_val    = disp_val_reg;
    assign disp_blank  = disp_blank_reg;
    assign chip_sel    = chip_sel_reg;
    assign left_digit  = left_reg;
    assign right_digit = right_reg;
    assign digit_count = count_reg;
    assign key_event   = key_event_reg;

endmodule

// File: tb/tb_ssd_scan_scheduler.sv
// Self-checking bench for ssd_scan_scheduler (DWELL=10, blank=2, 24-cycle frame).
module tb_ssd_scan_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic       toggle_pulse;
    logic       clear;
    logic       key_valid;
    logic [3:0] key_code;
    logic [3:0] disp_val;
    logic       disp_blank;
    logic       chip_sel;
    logic [3:0] left_digit;
    logic [3:0] right_digit;
    logic [1:0] digit_count;
    logic       key_event;

    int checks = 0;
    int errors = 0;

    // Reference model of the entry register and scoreboard of {left,right,count}
    logic [3:0] ml = 4'd0;
    logic [3:0] mr = 4'd0;
    logic [1:0] mc = 2'd0;
    logic [9:0] exp_q[$];

    ssd_scan_scheduler #(
        .clk_freq    (1000),
        .refresh_hz  (50),
        .blank_cycles(2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .toggle_pulse(toggle_pulse),
        .clear       (clear),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .disp_val    (disp_val),
        .disp_blank  (disp_blank),
        .chip_sel    (chip_sel),
        .left_digit  (left_digit),
        .right_digit (right_digit),
        .digit_count (digit_count),
        .key_event   (key_event)
    );

    always #5 clk = ~clk;

    function automatic logic frame_sel(input int k);
        int p;
        p = k % 24;
        return (p >= 10 && p < 22) ? 1'b1 : 1'b0;
    endfunction

    task automatic test_reset();
        rst = 1'b1; mode = 1'b1; toggle_pulse = 1'b0; clear = 1'b0;
        key_valid = 1'b0; key_code = 4'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({disp_val, disp_blank, chip_sel, left_digit, right_digit, digit_count, key_event} !==
            {4'd0, 1'b1, 1'b0, 4'd0, 4'd0, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got val=%h blank=%b sel=%b l=%h r=%h cnt=%0d ev=%b, required 0 1 0 0 0 0 0",
                     disp_val, disp_blank, chip_sel, left_digit, right_digit, digit_count, key_event);
        end
        rst = 1'b0;
    endtask

    task automatic test_scan_empty();
        for (int k = 0; k < 48; k++) begin
            checks++;
            if (chip_sel !== frame_sel(k) || disp_blank !== 1'b1) begin
                errors++;
                $display("FAIL scan_empty k=%0d: got sel=%b blank=%b, required sel=%b blank=1",
                         k, chip_sel, disp_blank, frame_sel(k));
            end
            @(negedge clk);
        end
        $display("scan_empty: 48 cycles checked");
    endtask

    // Called at a negedge; leaves at a negedge with key_valid low after idle cycles.
    task automatic press(input logic [3:0] code, input int hold, input int idle);
        int got;
        logic [9:0] e;
        got = 0;
        key_valid = 1'b1;
        key_code  = code;
        ml = mr;
        mr = code;
        if (mc != 2'd2) mc = mc + 2'd1;
        exp_q.push_back({ml, mr, mc});
        for (int i = 1; i <= hold; i++) begin
            @(negedge clk);
            if (key_event === 1'b1) begin
                got++;
                checks++;
                if (i != 2) begin
                    errors++;
                    $display("FAIL press_latency code=%h: event at cycle %0d, required 2", code, i);
                end
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL press_unexpected code=%h: event with empty scoreboard", code);
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if ({left_digit, right_digit, digit_count} !== e) begin
                        errors++;
                        $display("FAIL press_digits code=%h: got l=%h r=%h cnt=%0d, required l=%h r=%h cnt=%0d",
                                 code, left_digit, right_digit, digit_count, e[9:6], e[5:2], e[1:0]);
                    end
                end
            end
        end
        key_valid = 1'b0;
        for (int i = 0; i < idle; i++) begin
            @(negedge clk);
            if (key_event === 1'b1) got++;
        end
        checks++;
        if (got != 1) begin
            errors++;
            $display("FAIL press_event_count code=%h: got %0d pulses, required 1", code, got);
        end
        $display("press %h hold=%0d: l=%h r=%h cnt=%0d events=%0d", code, hold,
                 left_digit, right_digit, digit_count, got);
    endtask

    task automatic test_scan_digits();
        int nonblank;
        nonblank = 0;
        for (int k = 0; k < 24; k++) begin
            if (disp_blank === 1'b0) begin
                nonblank++;
                checks++;
                if (disp_val !== (chip_sel ? 4'h3 : 4'h7)) begin
                    errors++;
                    $display("FAIL scan_digit: sel=%b got %h, required %h", chip_sel, disp_val,
                             chip_sel ? 4'h3 : 4'h7);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (nonblank != 20) begin
            errors++;
            $display("FAIL scan_shown_cycles: got %0d, required 20", nonblank);
        end
        $display("scan_digits: %0d shown cycles", nonblank);
    endtask

    task automatic test_clear_with_press();
        int ev;
        ev = 0;
        clear = 1'b1; key_valid = 1'b1; key_code = 4'h5;
        @(negedge clk);
        clear = 1'b0;
        ml = 4'd0; mr = 4'd0; mc = 2'd0;
        checks++;
        if ({left_digit, right_digit, digit_count} !== {ml, mr, mc}) begin
            errors++;
            $display("FAIL clear_digits: got l=%h r=%h cnt=%0d, required 0 0 0",
                     left_digit, right_digit, digit_count);
        end
        for (int i = 0; i < 8; i++) begin
            if (key_event === 1'b1) ev++;
            @(negedge clk);
        end
        key_valid = 1'b0;
        checks++;
        if (ev != 0 || digit_count !== 2'd0) begin
            errors++;
            $display("FAIL clear_press_dropped: got events=%0d cnt=%0d, required 0 0", ev, digit_count);
        end
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            checks++;
            if (disp_blank !== 1'b1) begin
                errors++;
                $display("FAIL clear_blank: sel=%b got blank=%b, required 1", chip_sel, disp_blank);
            end
        end
        $display("clear_with_press: events=%0d cnt=%0d", ev, digit_count);
    endtask

    task automatic test_static_toggle();
        logic exp_sel;
        press(4'h9, 5, 2);
        mode = 1'b0;
        @(negedge clk);
        exp_sel = 1'b0;
        checks++;
        if (chip_sel !== exp_sel || disp_val !== 4'h9 || disp_blank !== 1'b0) begin
            errors++;
            $display("FAIL static_entry: got sel=%b val=%h blank=%b, required 0 9 0",
                     chip_sel, disp_val, disp_blank);
        end
        for (int t = 0; t < 3; t++) begin
            toggle_pulse = 1'b1;
            @(negedge clk);
            toggle_pulse = 1'b0;
            exp_sel = ~exp_sel;
            checks++;
            if (chip_sel !== exp_sel || disp_val !== 4'h9 || disp_blank !== 1'b0) begin
                errors++;
                $display("FAIL static_toggle %0d: got sel=%b val=%h blank=%b, required %b 9 0",
                         t, chip_sel, disp_val, disp_blank, exp_sel);
            end
            @(negedge clk);
            $display("toggle %0d: sel=%b", t, chip_sel);
        end
        mode = 1'b1;
        @(negedge clk);
        checks++;
        if (chip_sel !== 1'b1 || disp_blank !== 1'b1) begin
            errors++;
            $display("FAIL scan_entry_blank_l: got sel=%b blank=%b, required 1 1", chip_sel, disp_blank);
        end
        // toggle_pulse is ignored while scanning; the register keeps its 1
        toggle_pulse = 1'b1;
        @(negedge clk);
        toggle_pulse = 1'b0;
        @(negedge clk);
        mode = 1'b0;
        @(negedge clk);
        checks++;
        if (chip_sel !== 1'b1 || disp_val !== 4'h9) begin
            errors++;
            $display("FAIL static_return: got sel=%b val=%h, required 1 9", chip_sel, disp_val);
        end
        mode = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        int waited;
        press(4'h4, 5, 2);
        waited = 0;
        while (!(chip_sel === 1'b1 && disp_blank === 1'b0) && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (waited >= 60 || disp_val !== 4'h9) begin
            errors++;
            $display("FAIL show_l_reached: waited=%0d val=%h, required SHOW_L showing 9", waited, disp_val);
        end
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({disp_val, disp_blank, chip_sel, left_digit, right_digit, digit_count, key_event} !==
            {4'd0, 1'b1, 1'b0, 4'd0, 4'd0, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got val=%h blank=%b sel=%b l=%h r=%h cnt=%0d ev=%b, required 0 1 0 0 0 0 0",
                     disp_val, disp_blank, chip_sel, left_digit, right_digit, digit_count, key_event);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 24; k++) begin
            checks++;
            if (chip_sel !== frame_sel(k)) begin
                errors++;
                $display("FAIL restart_show_r k=%0d: got sel=%b, required %b", k, chip_sel, frame_sel(k));
            end
            @(negedge clk);
        end
        $display("async_reset: restart frame checked");
    endtask

    initial begin
        test_reset();
        test_scan_empty();
        press(4'h3, 5, 5);
        press(4'h7, 5, 5);
        test_scan_digits();
        press(4'hA, 5, 5);
        press(4'hB, 50, 5);
        test_clear_with_press();
        test_static_toggle();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ssd_scan_scheduler.md
Name: ssd_scan_scheduler

Overview:
- Sequences the two-digit seven-segment Pmod from keypad entries.
- Captures decoded key presses into a two-digit entry register. In scan mode it time-multiplexes chip_sel between the right and left digits, with a blanking gap at each switch to suppress ghosting.
- In static mode it holds chip_sel and toggles it on a button pulse.
- Sits between keypad_decoder (key_valid/key_code) and disp_ctrl (disp_val → seg); chip_sel drives the Pmod digit select.

Parameters:
- clk_freq, 125_000_000, input clock frequency in Hz.
- refresh_hz, 100, full left+right refresh rate in Hz. Show dwell DWELL = clk_freq/(2*refresh_hz) cycles per digit; DWELL >= 1 is required.
- blank_cycles, 1250, cycles in each blank state on a digit switch; must be >= 1.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- mode  input  1  0 = static single-digit, 1 = two-digit scan
- toggle_pulse  input  1  one-cycle pulse (debounced btn); flips chip_sel in static mode
- clear  input  1  level/pulse; empties the entry register
- key_valid  input  1  level, high while a key is held (clk domain)
- key_code  input  4  decoded key value, stable while key_valid is high
- disp_val  output  4  nibble to disp_ctrl
- disp_blank  output  1  1 = segments must be off
- chip_sel  output  1  0 = right digit, 1 = left digit
- left_digit  output  4  older entry
- right_digit  output  4  newest entry
- digit_count  output  2  valid entries, 0..2, saturating
- key_event  output  1  one-cycle pulse per accepted press

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset values: disp_val=0, disp_blank=1, chip_sel=0, left_digit=0, right_digit=0, digit_count=0, key_event=0. Scan FSM enters SHOW_R with the dwell counter at 0; the static toggle register is 0.
- All outputs are registered.

Key capture:
- Press detection: internal registered key_valid; a press is key_valid=1 with the previous value 0.
- On a press sampled at edge N, at edge N+1:
  - left_digit ← right_digit; right_digit ← key_code.
  - digit_count ← min(count+1, 2).
  - key_event=1 for exactly one cycle.
- Held key: no repeat. A release followed by a re-press counts as a new press.
- clear=1: digits ← 0 and count ← 0 at the next edge.
- clear and a press in the same cycle: clear wins, the press is dropped, key_event=0.
- A key_valid rise is still detected if clear deasserts while the key is held only when a genuine 0→1 transition occurs afterward.

Scan FSM (mode=1):
- States and chip_sel:
  - SHOW_R: chip_sel=0.
  - BLANK_L: chip_sel=1.
  - SHOW_L: chip_sel=1.
  - BLANK_R: chip_sel=0.
- Durations: SHOW_R and SHOW_L last DWELL cycles; BLANK_L and BLANK_R last blank_cycles.
- Order: SHOW_R → BLANK_L → SHOW_L → BLANK_R → SHOW_R.
- Counter behaviour: the counter resets to 0 on every transition. A transition occurs when counter == duration-1.
- chip_sel changes on entry to a blank state only, never during a SHOW state.
- disp_blank=1 in both blank states.
- In SHOW_R: disp_val=right_digit; blank if digit_count==0.
- In SHOW_L: disp_val=left_digit; blank if digit_count<2.
- Digit updates during SHOW are visible from the next cycle with no FSM disturbance.

Static mode (mode=0):
- The FSM is held in SHOW_R with the counter at 0.
- chip_sel = toggle register; toggle_pulse flips it at the next edge.
- disp_val=right_digit; disp_blank = (digit_count==0).
- toggle_pulse is ignored in mode=1, and the register keeps its value.

Mode change:
- 1→0: the next cycle follows static rules (chip_sel = toggle register).
- 0→1: the FSM enters BLANK_L with the counter at 0 on the next edge, so the first switch is blanked.

Boundaries:
- digit_count saturates at 2; further presses keep shifting.
- Counters are sized for max(DWELL, blank_cycles) with no wrap beyond the terminal value.
- rst mid-scan forces reset values immediately, regardless of the clock.

Test Plan:
- Reset, then mode=1 with clk_freq=1000, refresh_hz=50 (DWELL=10) and blank_cycles=2 → chip_sel period 24 cycles: 10 low + 2 high-blank + 10 high + 2 low-blank. disp_blank=1 throughout with no keys entered.
- Presses of 0x3 then 0x7, each 5 cycles long and separated by 5 idle cycles → key_event has exactly 2 pulses, each one cycle after its rise. Result: left=3, right=7, count=2. In scan, disp_val is 7 while chip_sel=0 (SHOW) and 3 while chip_sel=1 (SHOW).
- Third press 0xA → left=7, right=A, count stays 2. A key held for 50 cycles → one key_event only.
- clear asserted in the same cycle as a press rise of 0x5 → digits 0, count 0, no key_event, display blanked in both SHOW states.
- mode=0 with right=9 and toggle_pulse ×3 → chip_sel goes 1,0,1 at the edge after each pulse, disp_val=9, disp_blank=0. Switching to mode=1 → next state is BLANK_L with disp_blank=1.
- rst asserted asynchronously mid-SHOW_L → outputs return to reset values before the next clk edge. After release the FSM restarts in SHOW_R.
